// File: rtl/fdiv_seq.sv
// Purpose : sequential IEEE-754 single-precision divider (y = x1 / x2), restoring
//           radix-2 mantissa division, truncating normalisation, no NaN/Inf detection.
// Latency : 25 edges after the capture edge for normal operands; special operands
//           (zero/denormal exponent) resolve on the capture edge itself.
// Backpr. : in_ready only in IDLE; result held in DONE until out_ready, one op at a time.
//
// Ports:
//   clk       - sole clock, rising edge
//   rstn      - asynchronous active-low reset
//   x1, x2    - dividend / divisor, captured on in_valid && in_ready
//   in_valid  - operands present
//   in_ready  - block idle and able to accept operands
//   y         - quotient, stable while out_valid
//   out_valid - y holds a result
//   out_ready - consumer accepts y

module fdiv_seq (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        r_sy;      // result sign, s1 ^ s2
    logic [7:0]  r_e1;      // captured dividend exponent
    logic [7:0]  r_e2;      // captured divisor exponent
    logic [22:0] r_m2;      // captured divisor mantissa (dividend mantissa lives in r_rem)
    logic [4:0]  r_cnt;     // index of the quotient bit produced this DIV cycle
    logic [24:0] r_rem;     // partial remainder, always < 2*mb
    logic [24:0] r_q;       // quotient, q[24] has weight 1
    logic [31:0] r_y;

    // ------------------------------------------------------------------
    // Capture-time special operand handling (works on live inputs)
    // ------------------------------------------------------------------
    logic        w_sy_in;
    logic        w_spec_in;
    logic [31:0] w_y_spec;

    assign w_sy_in   = x1[31] ^ x2[31];
    assign w_spec_in = (x1[30:23] == 8'd0) || (x2[30:23] == 8'd0);

    // A zero/denormal dividend wins over a zero/denormal divisor.
    always_comb begin
        w_y_spec = {w_sy_in, 31'd0};
        if (x1[30:23] != 8'd0) begin
            w_y_spec = {w_sy_in, 8'hFF, 23'd0};
        end
    end

    // ------------------------------------------------------------------
    // One restoring division step
    // ------------------------------------------------------------------
    logic [23:0] w_mb;
    logic        w_ge;
    logic [23:0] w_diff;
    logic [24:0] w_rem_nxt;
    logic [24:0] w_q_nxt;

    assign w_mb = {1'b1, r_m2};
    assign w_ge = (r_rem >= {1'b0, w_mb});
    // When rem >= mb the difference is below mb < 2^24, so 24 bits suffice.
    assign w_diff    = r_rem[23:0] - w_mb;
    assign w_rem_nxt = w_ge ? {w_diff, 1'b0} : {r_rem[23:0], 1'b0};
    assign w_q_nxt   = w_ge ? (r_q | (25'd1 << r_cnt)) : r_q;

    // ------------------------------------------------------------------
    // Normalisation of the final quotient (uses w_q_nxt so the last bit
    // produced on the cnt==0 cycle is included)
    // ------------------------------------------------------------------
    logic signed [9:0] w_ea_base;
    logic signed [9:0] w_ea;
    logic [22:0]       w_my;
    logic [31:0]       w_y_norm;

    // e1-e2 spans -254..254, plus bias up to 381: fits a 10-bit signed value.
    assign w_ea_base = $signed({2'b00, r_e1}) - $signed({2'b00, r_e2});
    assign w_ea      = w_ea_base + (w_q_nxt[24] ? 10'sd127 : 10'sd126);
    assign w_my      = w_q_nxt[24] ? w_q_nxt[23:1] : w_q_nxt[22:0];

    always_comb begin
        w_y_norm = {r_sy, w_ea[7:0], w_my};
        if (w_ea <= 10'sd0) begin
            w_y_norm = {r_sy, 31'd0};
        end else if (w_ea >= 10'sd255) begin
            w_y_norm = {r_sy, 8'hFF, 23'd0};
        end
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_sy    <= 1'b0;
            r_e1    <= 8'd0;
            r_e2    <= 8'd0;
            r_m2    <= 23'd0;
            r_cnt   <= 5'd0;
            r_rem   <= 25'd0;
            r_q     <= 25'd0;
            r_y     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sy <= w_sy_in;
                        r_e1 <= x1[30:23];
                        r_e2 <= x2[30:23];
                        r_m2 <= x2[22:0];
                        if (w_spec_in) begin
                            r_y     <= w_y_spec;
                            r_state <= S_DONE;
                        end else begin
                            r_rem   <= {2'b01, x1[22:0]};
                            r_q     <= 25'd0;
                            r_cnt   <= 5'd24;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    if (r_cnt == 5'd0) begin
                        r_y     <= w_y_norm;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    // The handshake edge only returns to IDLE; in_ready is low
                    // here, so no new operand can be taken on the same edge.
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign y         = r_y;

endmodule
